data_memo: RTL and testbench
============================

// Module: data_memo
// PURPOSE
//   Word-addressed data memory for the MEM stage of the 5-stage pipeline.
//   Writes are synchronous, gated by the final (post-kill) write enable.
//   Reads are combinational and gated by a read enable.
//   Data_out feeds the MEM/WB buffer; Address comes from the ALU result.
// PARAMETERS
//   DATA_W  32   word width in bits
//   ADDR_W  32   width of the Address port
//   DEPTH   256  number of words; power of two, >= 32
// PORTS
//   clk          in   1       clock; all writes occur on its rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   MemRd        in   1       read enable
//   MemWr_final  in   1       write enable (already qualified by kill/stall)
//   Address      in   ADDR_W  word index, not a byte address
//   Data_in      in   DATA_W  write data
//   Data_out     out  DATA_W  read data
//   Addr_err     out  1       out-of-range flag (only with DMEM_RANGE_CHK_EN)
// BEHAVIOUR
//   - Index = Address[log2(DEPTH)-1:0]. Storage is mem[0..DEPTH-1] of DATA_W bits.
//   - Reset:
//     - reset_n low immediately clears every word to 0, regardless of clk.
//     - Data_out then reads 0 (if MemRd=1) or 0 (if MemRd=0).
//     - reset_n low blocks all writes; reset wins over a coincident write edge.
//     - Reset release is synchronised to avoid races: the first write is
//       accepted on the first rising edge after reset_n has been high for a
//       full cycle.
//   - Write:
//     - On posedge clk with MemWr_final=1, mem[index] <= Data_in.
//     - MemWr_final=0 leaves all words unchanged, whatever Address/Data_in are.
//     - MemRd has no effect on writes.
//   - Read:
//     - Data_out = MemRd ? mem[index] : 0, purely combinational (0-cycle latency).
//     - Data_out follows Address/MemRd changes within the same cycle.
//   - Simultaneous read and write to the same index:
//     - Before the edge, Data_out shows the old word.
//     - After the edge, it shows Data_in.
//     - No write-through bypass.
//   - Address bits above the index width are ignored; accesses wrap modulo
//     DEPTH, except as modified by DMEM_RANGE_CHK_EN.
//   - No X on Data_out after reset; every word is defined.
// CONFIGURATION
//   - DMEM_RANGE_CHK_EN defined:
//     - Addr_err port exists.
//     - Addr_err = (MemRd|MemWr_final) & (Address >= DEPTH), combinational.
//     - An out-of-range write is suppressed (memory unchanged).
//     - An out-of-range read returns 0.
//   - DMEM_RANGE_CHK_EN undefined:
//     - No Addr_err port.
//     - Upper Address bits are ignored (wrap-around).
// TESTING
//   - Write, then read back:
//     - MemWr_final=1, Address=10, Data_in=AAAA5555, one posedge.
//     - Then MemRd=1 -> Data_out=AAAA5555.
//   - Read disabled: MemRd=0 at Address=10 -> Data_out=00000000.
//   - Independent addresses:
//     - Write 12345678 at 20, MemRd=1 -> Data_out=12345678.
//     - Address=10 -> Data_out=AAAA5555, visible without a clock edge.
//   - Write disabled:
//     - MemWr_final=0, Address=10, Data_in=FFFFFFFF, posedge.
//     - Read -> Data_out=AAAA5555.
//   - Asynchronous reset:
//     - Pulse reset_n low between clock edges.
//     - Read 10 and 20 -> both 00000000.
//     - A write asserted during reset is lost.
//   - Range check (DMEM_RANGE_CHK_EN):
//     - Write at Address=DEPTH -> Addr_err=1; mem[0] unchanged.
//     - Without the macro, the same write lands in mem[0].

Source files
------------

// File: rtl/data_memo_if.sv
// Bus bundle for the MEM-stage data memory: read/write enables, word address and data.
// Addr_err exists only when DMEM_RANGE_CHK_EN is defined.
interface data_memo_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              MemRd;
   logic              MemWr_final;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] Data_in;
   logic [DATA_W-1:0] Data_out;
`ifdef DMEM_RANGE_CHK_EN
   logic              Addr_err;

   modport master (output MemRd, MemWr_final, Address, Data_in,
                   input  Data_out, Addr_err);
   modport slave  (input  MemRd, MemWr_final, Address, Data_in,
                   output Data_out, Addr_err);
`else
   modport master (output MemRd, MemWr_final, Address, Data_in,
                   input  Data_out);
   modport slave  (input  MemRd, MemWr_final, Address, Data_in,
                   output Data_out);
`endif
endinterface

// File: rtl/data_memo.sv
// Word-addressed data memory: synchronous write, combinational gated read, async clear.
// Optional out-of-range checking is enabled with DMEM_RANGE_CHK_EN.
module data_memo #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 256
) (
   input  logic         clk,
   input  logic         reset_n,
   data_memo_if.slave   bus
);
   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  idx;
   logic              wr_arm;
   logic              wr_ok;
   logic              rd_ok;
   logic              unused_addr_hi;

   assign idx            = bus.Address[IDX_W-1:0];
   assign unused_addr_hi = ^bus.Address[ADDR_W-1:IDX_W];

`ifdef DMEM_RANGE_CHK_EN
   logic oor;
   assign oor          = (bus.Address >= ADDR_W'(DEPTH));
   assign bus.Addr_err = (bus.MemRd | bus.MemWr_final) & oor;
   assign wr_ok        = bus.MemWr_final & ~oor;
   assign rd_ok        = bus.MemRd & ~oor;
`else
   assign wr_ok        = bus.MemWr_final;
   assign rd_ok        = bus.MemRd;
`endif

   // Writes stay blocked until reset_n has been seen high on one clock edge,
   // so a release landing near an edge can never race a write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wr_arm <= 1'b0;
      else          wr_arm <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_arm && wr_ok) begin
         mem[idx] <= bus.Data_in;
      end
   end

   assign bus.Data_out = rd_ok ? mem[idx] : '0;
endmodule

// File: tb/tb_data_memo.sv
// Self-checking bench for data_memo: directed cases plus randomized traffic
// against an array model. Build with DMEM_RANGE_CHK_EN to cover range checking.
module tb_data_memo;
   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic reset_n;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] model [DEPTH];

   data_memo_if #(.DATA_W(32), .ADDR_W(32)) bus ();
   data_memo #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic bit out_of_range(input logic [31:0] a);
`ifdef DMEM_RANGE_CHK_EN
      return a >= 32'(DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] ref_read(input logic rd, input logic [31:0] a);
      if (!rd || out_of_range(a)) return 32'h0;
      return model[a % DEPTH];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
   endtask

   task automatic check_read(input string name, input logic rd, input logic [31:0] a,
                             input logic [31:0] exp);
      @(negedge clk);
      bus.MemWr_final = 1'b0;
      bus.MemRd       = rd;
      bus.Address     = a;
      #1;
      vectors++;
      if (bus.Data_out !== exp) begin
         miscompares++;
         $display("FAIL %s: addr=%0d Data_out=%h required=%h", name, a, bus.Data_out, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.MemRd       = 1'b0;
      bus.MemWr_final = 1'b1;
      bus.Address     = a;
      bus.Data_in     = d;
      @(posedge clk);
      #1;
      bus.MemWr_final = 1'b0;
      if (!out_of_range(a)) model[a % DEPTH] = d;
   endtask

   task automatic test_reset();
      check_read("reset_addr0",   1'b1, 32'd0,   32'h0);
      check_read("reset_addr10",  1'b1, 32'd10,  32'h0);
      check_read("reset_addr255", 1'b1, 32'd255, 32'h0);
      check_read("reset_rd_off",  1'b0, 32'd20,  32'h0);
   endtask

   task automatic test_write_read();
      do_write(32'd10, 32'hAAAA5555);
      check_read("wr_rd_10", 1'b1, 32'd10, 32'hAAAA5555);
   endtask

   task automatic test_read_disable();
      check_read("rd_disabled_10", 1'b0, 32'd10, 32'h0);
   endtask

   task automatic test_independent();
      do_write(32'd20, 32'h12345678);
      check_read("indep_20", 1'b1, 32'd20, 32'h12345678);
      // Address change without an intervening edge
      bus.Address = 32'd10;
      #1;
      vectors++;
      if (bus.Data_out !== 32'hAAAA5555) begin
         miscompares++;
         $display("FAIL indep_comb_10: Data_out=%h required=AAAA5555", bus.Data_out);
      end
   endtask

   task automatic test_write_disable();
      @(negedge clk);
      bus.MemWr_final = 1'b0;
      bus.MemRd       = 1'b0;
      bus.Address     = 32'd10;
      bus.Data_in     = 32'hFFFFFFFF;
      @(posedge clk);
      #1;
      check_read("wr_disabled_10", 1'b1, 32'd10, 32'hAAAA5555);
   endtask

   task automatic test_same_index();
      @(negedge clk);
      bus.MemRd       = 1'b1;
      bus.MemWr_final = 1'b1;
      bus.Address     = 32'd20;
      bus.Data_in     = 32'hCAFEF00D;
      #1;
      vectors++;
      if (bus.Data_out !== model[20]) begin
         miscompares++;
         $display("FAIL rw_same_before: Data_out=%h required=%h", bus.Data_out, model[20]);
      end
      @(posedge clk);
      #1;
      bus.MemWr_final = 1'b0;
      model[20] = 32'hCAFEF00D;
      vectors++;
      if (bus.Data_out !== 32'hCAFEF00D) begin
         miscompares++;
         $display("FAIL rw_same_after: Data_out=%h required=CAFEF00D", bus.Data_out);
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      clear_model();
      bus.MemRd = 1'b1;
      bus.MemWr_final = 1'b0;
      bus.Address = 32'd10;
      #1;
      vectors++;
      if (bus.Data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_clear_10: Data_out=%h required=00000000", bus.Data_out);
      end
      bus.Address = 32'd20;
      #1;
      vectors++;
      if (bus.Data_out !== 32'h0) begin
         miscompares++;
         $display("FAIL async_clear_20: Data_out=%h required=00000000", bus.Data_out);
      end
      // Write attempted while reset is held
      bus.MemRd = 1'b0;
      bus.MemWr_final = 1'b1;
      bus.Address = 32'd10;
      bus.Data_in = 32'h5A5A5A5A;
      @(posedge clk);
      #3;
      // Release mid-cycle; the first edge after release must still block writes
      reset_n = 1'b1;
      bus.Address = 32'd11;
      bus.Data_in = 32'h11111111;
      @(posedge clk);
      #1;
      bus.Address = 32'd12;
      bus.Data_in = 32'h22222222;
      @(posedge clk);
      #1;
      bus.MemWr_final = 1'b0;
      model[12] = 32'h22222222;
      check_read("reset_wr_lost_10",  1'b1, 32'd10, 32'h0);
      check_read("release_edge1_11",  1'b1, 32'd11, 32'h0);
      check_read("release_edge2_12",  1'b1, 32'd12, 32'h22222222);
   endtask

   task automatic test_range();
      do_write(32'd0, 32'h0BADBEEF);
      @(negedge clk);
      bus.MemRd       = 1'b0;
      bus.MemWr_final = 1'b1;
      bus.Address     = 32'(DEPTH);
      bus.Data_in     = 32'hDEADC0DE;
      #1;
`ifdef DMEM_RANGE_CHK_EN
      vectors++;
      if (bus.Addr_err !== 1'b1) begin
         miscompares++;
         $display("FAIL range_err_flag: Addr_err=%b required=1", bus.Addr_err);
      end
`endif
      @(posedge clk);
      #1;
      bus.MemWr_final = 1'b0;
      if (!out_of_range(32'(DEPTH))) model[0] = 32'hDEADC0DE;
`ifdef DMEM_RANGE_CHK_EN
      check_read("range_mem0_kept", 1'b1, 32'd0, 32'h0BADBEEF);
      check_read("range_oor_read",  1'b1, 32'(DEPTH), 32'h0);
`else
      check_read("wrap_mem0_written", 1'b1, 32'd0, 32'hDEADC0DE);
      check_read("wrap_read_depth",   1'b1, 32'(DEPTH), 32'hDEADC0DE);
`endif
   endtask

   task automatic test_random();
      logic        rd, wr;
      logic [31:0] a, d, exp;
      for (int n = 0; n < 400; n++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, DEPTH + 3));
         d  = $urandom;
         @(negedge clk);
         bus.MemRd = rd;
         bus.MemWr_final = wr;
         bus.Address = a;
         bus.Data_in = d;
         #1;
         exp = ref_read(rd, a);
         vectors++;
         if (bus.Data_out !== exp) begin
            miscompares++;
            $display("FAIL random_read: iter=%0d addr=%h Data_out=%h required=%h",
                     n, a, bus.Data_out, exp);
         end
`ifdef DMEM_RANGE_CHK_EN
         vectors++;
         if (bus.Addr_err !== ((rd | wr) & out_of_range(a))) begin
            miscompares++;
            $display("FAIL random_addr_err: iter=%0d addr=%h Addr_err=%b required=%b",
                     n, a, bus.Addr_err, (rd | wr) & out_of_range(a));
         end
`endif
         @(posedge clk);
         #1;
         if (wr && !out_of_range(a)) model[a % DEPTH] = d;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) do_write(32'(40 + i), 32'hB0B0_0000 + 32'(i));
      for (int i = 0; i < 8; i++)
         check_read("b2b_read", 1'b1, 32'(40 + i), ref_read(1'b1, 32'(40 + i)));
   endtask

   initial begin
      reset_n = 1'b0;
      bus.MemRd = 1'b0;
      bus.MemWr_final = 1'b0;
      bus.Address = '0;
      bus.Data_in = '0;
      clear_model();
      repeat (2) @(posedge clk);
      #3;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_write_read();
      test_read_disable();
      test_independent();
      test_write_disable();
      test_same_index();
      test_async_reset();
      test_range();
      test_random();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
